dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port, word-addressed data memory (synchronous write, combinational read) of the MIPS-Lite processor. It shares the memory between the processor data port (port 0) and a loader/DMA engine (port 1). Arbitration is round-robin, with an optional bounded lock for bursts. Read data is returned through a registered response path, and out-of-range accesses are flagged.

## Interface
- DEPTH, 64, memory depth in words; legal word index is addr[31:2] < DEPTH
- MAX_BURST, 4, maximum consecutive locked grants to one port while the other port is requesting (≥1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- lock0 / lock1  in  1  request to keep ownership on the next cycle
- addr0 / addr1  in  32  byte address; bits [1:0] are ignored
- wd0 / wd1  in  32  write data
- gnt0 / gnt1  out  1  combinational grant; the access executes in this cycle
- rvalid0 / rvalid1  out  1  registered one-cycle pulse carrying read data
- rdata0 / rdata1  out  32  registered read data, valid while rvalid is high
- err0 / err1  out  1  registered pulse: the access granted last cycle was out of range
- mem_we  out  1  memory write enable
- mem_addr  out  32  address to memory, forwarded from the granted port
- mem_wd  out  32  write data to memory
- mem_rd  in  32  combinational read data from memory

## Operation
- State registers:
  - last: port granted most recently; reset value 1, so port 0 wins first.
  - burst_cnt: consecutive grants to `last`, range 0..MAX_BURST, saturating.
- Grant decision, combinational, at most one grant per cycle:
  - Neither req: no grant. mem_we=0; mem_addr/mem_wd = port 0 values (don't care).
  - One req: grant that port.
  - Both req, locked: if lock[last]=1 and burst_cnt < MAX_BURST, grant `last`.
  - Both req, otherwise: grant the port that is not `last`.
- On each grant, at the clock edge:
  - Same port as `last`: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Other port: last ← port, burst_cnt ← 1.
  - No grant: burst_cnt ← 0; `last` is unchanged.
- Memory drive during a grant:
  - mem_addr and mem_wd come from the granted port.
  - mem_we = we of the granted port AND in-range (addr[31:2] < DEPTH).
- Response, registered at the edge after a granted read:
  - rvalidN=1.
  - rdataN = mem_rd if in range, else 32'h0.
  - errN=1 if out of range, for reads and writes alike.
- Granted writes produce no rvalid; the gnt cycle is their completion.
- Out-of-range writes are dropped (mem_we stays 0) and err pulses the next cycle.
- rdataN holds its last value when rvalidN=0.
- A requester must hold req/we/addr/wd stable until gnt is sampled high. Deasserting req before grant is legal; no access occurs.

## Timing
- Reset (async assert, release synchronized by the caller):
  - rvalid0/1=0, err0/1=0, rdata0/1=0, last=1, burst_cnt=0.
  - gnt0/1 are forced to 0 while reset_n=0, so mem_we=0.
- Read latency: granted in cycle N, rvalid/rdata in cycle N+1.
- Write: the memory is written at the rising edge that ends the gnt cycle.
- Throughput: one access per cycle.
- Both ports requesting continuously, no lock: strict alternation 0,1,0,1…
- Locked port: at most MAX_BURST consecutive grants while the other port requests, then one grant to the other port.
- Lock has no effect when the other port is idle; grants continue and burst_cnt saturates.
- Reset asserted mid-access: the in-flight response is discarded (rvalid=0) and the memory write in that cycle is suppressed.
- Read then write to the same address in consecutive cycles: the read returns the old data, because the read completes before the write edge.

## Test plan
- Reset, then req0 read addr 0x8 with mem[2]=0xDEADBEEF → gnt0 in cycle 1; rvalid0=1 and rdata0=0xDEADBEEF in cycle 2; err0=0.
- req0 and req1 held high for 6 cycles, lock=0 → grant order 0,1,0,1,0,1.
- MAX_BURST=4; lock1=1 and req1 held after port 1 wins; req0 held → grants 1,1,1,1,0, then 1 if lock1 remains set.
- Port 1 writes 0x12345678 to addr 0x10, port 0 reads 0x10 next cycle → mem_we in cycle N only; rdata0=0x12345678 in cycle N+2.
- Port 0 writes to addr 0x100 (word 64, DEPTH=64) → mem_we=0, err0=1 next cycle, memory unchanged. Port 0 read of the same address → rdata0=0, err0=1.
- Assert reset_n=0 during a granted port 1 read → rvalid1 stays 0; after release, port 0 wins the first simultaneous request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the MIPS-Lite data memory. Port 0 is the
// processor data port and port 1 is the loader/DMA engine. A port can hold
// ownership for a bounded burst by asserting lock. Read data comes back one
// cycle after the grant on a registered path. Out-of-range accesses raise err.
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
    localparam logic [29:0] DepthW = 30'(DEPTH);

    // Port granted most recently (0 or 1) and its count of consecutive grants.
    logic            r_last;
    logic [CntW-1:0] r_burst_cnt;

    logic            r_rvalid0;
    logic            r_rvalid1;
    logic [31:0]     r_rdata0;
    logic [31:0]     r_rdata1;
    logic            r_err0;
    logic            r_err1;

    logic            w_in_range0;
    logic            w_in_range1;
    logic            w_lock_last;
    logic            w_gnt0;
    logic            w_gnt1;

    assign w_in_range0 = (addr0[31:2] < DepthW);
    assign w_in_range1 = (addr1[31:2] < DepthW);
    assign w_lock_last = r_last ? lock1 : lock0;

    // Grant decision: single requester wins outright; contention goes to the
    // locked owner while its burst budget lasts, otherwise to the other port.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (w_lock_last && (r_burst_cnt < MaxCnt)) begin
                    w_gnt0 = ~r_last;
                    w_gnt1 = r_last;
                end else begin
                    w_gnt0 = r_last;
                    w_gnt1 = ~r_last;
                end
            end
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // Forward the granted port to memory; port 0 drives the bus when idle.
    always_comb begin
        mem_addr = addr0;
        mem_wd   = wd0;
        mem_we   = 1'b0;
        if (w_gnt1) begin
            mem_addr = addr1;
            mem_wd   = wd1;
            mem_we   = we1 & w_in_range1;
        end else if (w_gnt0) begin
            mem_we   = we0 & w_in_range0;
        end
    end

    // Round-robin owner and saturating burst counter; an idle cycle ends a burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
        end else if (w_gnt0 || w_gnt1) begin
            if (w_gnt1 == r_last) begin
                if (r_burst_cnt < MaxCnt) begin
                    r_burst_cnt <= r_burst_cnt + CntW'(1);
                end
            end else begin
                r_last      <= w_gnt1;
                r_burst_cnt <= CntW'(1);
            end
        end else begin
            r_burst_cnt <= '0;
        end
    end

    // Registered responses; rdata holds its value between read completions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            r_err0    <= w_gnt0 & ~w_in_range0;
            r_err1    <= w_gnt1 & ~w_in_range1;
            if (w_gnt0 && !we0) begin
                r_rdata0 <= w_in_range0 ? mem_rd : 32'h0;
            end
            if (w_gnt1 && !we1) begin
                r_rdata1 <= w_in_range1 ? mem_rd : 32'h0;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign err0    = r_err0;
    assign err1    = r_err1;

endmodule
